// File: rtl/mxpl_writer_if.sv
// Memory write port of the pooled-layer writer.
// The writer drives request, address and data, and the memory answers with ready.
interface mxpl_writer_if #(
  parameter int unsigned DATAW = 20,
  parameter int unsigned ADDRW = 12
);
  logic             mem_we;
  logic [ADDRW-1:0] mem_addr;
  logic [DATAW-1:0] mem_wdata;
  logic             mem_ready;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/mxpl_writer.sv
// Buffers max-pool results in a small FIFO and writes them to sequential addresses of the
// pooled-layer memory, flagging frame completion and lost results.
module mxpl_writer #(
  parameter int unsigned DATAW      = 20,
  parameter int unsigned ADDRW      = 12,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned OUT_H      = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DATAW-1:0] mxpl_data,
  input  logic             mxpl_done,
  mxpl_writer_if.master    mem,
  output logic             busy,
  output logic             frame_done,
  output logic             overflow
);

  localparam int unsigned FrameLen = OUT_W * OUT_H;
  localparam int unsigned CntW     = $clog2(FrameLen + 1);
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW     = PtrW + 1;

  localparam logic [CntW-1:0]  FrameCnt = CntW'(FrameLen);
  localparam logic [CntW-1:0]  LastCnt  = CntW'(FrameLen - 1);
  localparam logic [LvlW-1:0]  FullLvl  = LvlW'(FIFO_DEPTH);
  localparam logic [ADDRW-1:0] BaseAddr = ADDRW'(BASE_ADDR);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [DATAW-1:0] fifo_q [FIFO_DEPTH];
  logic [DATAW-1:0] fifo_d [FIFO_DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LvlW-1:0]  lvl_q, lvl_d;
  logic [CntW-1:0]  push_cnt_q, push_cnt_d;
  logic [CntW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic             ovf_q, ovf_d;

  logic empty, full, pop, push_req, push_ok;

  assign empty    = (lvl_q == '0);
  assign full     = (lvl_q == FullLvl);
  assign push_req = (state_q == StRun) && mxpl_done;
  assign pop      = mem.mem_we && mem.mem_ready;
  // A full FIFO still takes a value when the head leaves in the same cycle.
  assign push_ok  = push_req && (push_cnt_q < FrameCnt) && (!full || pop);

  assign mem.mem_we    = (state_q == StRun) && !empty;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = empty ? '0 : fifo_q[rd_ptr_q];
  assign busy          = (state_q == StRun);
  assign frame_done    = (state_q == StDone);
  assign overflow      = ovf_q;

  always_comb begin
    state_d    = state_q;
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    lvl_d      = lvl_q;
    push_cnt_d = push_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    addr_d     = addr_q;
    ovf_d      = ovf_q;

    if (start) begin
      // Restart wins over any strobe or transfer in the same cycle.
      state_d    = StRun;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      lvl_d      = '0;
      push_cnt_d = '0;
      wr_cnt_d   = '0;
      addr_d     = BaseAddr;
      ovf_d      = 1'b0;
    end else begin
      if (push_ok) begin
        fifo_d[wr_ptr_q] = mxpl_data;
        wr_ptr_d         = wr_ptr_q + 1'b1;
        push_cnt_d       = push_cnt_q + 1'b1;
      end else if (push_req || (state_q == StDone && mxpl_done)) begin
        ovf_d = 1'b1;
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        addr_d   = addr_q + 1'b1;
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (wr_cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end

      lvl_d = lvl_q + LvlW'(push_ok) - LvlW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fifo_q     <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      lvl_q      <= '0;
      push_cnt_q <= '0;
      wr_cnt_q   <= '0;
      addr_q     <= BaseAddr;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      lvl_q      <= lvl_d;
      push_cnt_q <= push_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      addr_q     <= addr_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mxpl_writer.sv
// Directed bench for mxpl_writer: a scoreboard of expected (address, data) writes is
// consumed by a write monitor; state flags are checked at hand-picked points.
module tb_mxpl_writer;

  localparam int unsigned DATAW = 20;
  localparam int unsigned ADDRW = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             mxpl_done;
  logic [DATAW-1:0] mxpl_data;
  logic             busy;
  logic             frame_done;
  logic             overflow;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_stray  = 0;
  int unsigned n_writes = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  mxpl_writer_if #(.DATAW(DATAW), .ADDRW(ADDRW)) mem_bus ();

  mxpl_writer #(
    .DATAW     (DATAW),
    .ADDRW     (ADDRW),
    .OUT_W     (32),
    .OUT_H     (32),
    .FIFO_DEPTH(4),
    .BASE_ADDR (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mxpl_data (mxpl_data),
    .mxpl_done (mxpl_done),
    .mem       (mem_bus),
    .busy      (busy),
    .frame_done(frame_done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_wr(input int unsigned a, input int unsigned d);
    exp_q.push_back({32'(a), 32'(d)});
  endtask

  task automatic strobe(input logic [DATAW-1:0] d);
    mxpl_data = d;
    mxpl_done = 1'b1;
    tick();
    mxpl_done = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_bus.mem_we && mem_bus.mem_ready) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_stray++;
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(mem_bus.mem_addr), {32'd0, mon_e[63:32]});
        check("wr_data", 64'(mem_bus.mem_wdata), {32'd0, mon_e[31:0]});
      end
    end
  end

  initial begin
    reset             = 1'b1;
    start             = 1'b0;
    mxpl_done         = 1'b0;
    mxpl_data         = '0;
    mem_bus.mem_ready = 1'b1;
    ticks(2);
    check("rst_we", mem_bus.mem_we, 0);
    check("rst_addr", mem_bus.mem_addr, 0);
    check("rst_wdata", mem_bus.mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;

    // Strobe in IDLE is ignored.
    strobe(20'h00055);
    tick();
    check("idle_overflow", overflow, 0);
    check("idle_we", mem_bus.mem_we, 0);
    check("idle_busy", busy, 0);

    // Full frame, one strobe every 4 cycles.
    do_start();
    check("run_busy", busy, 1);
    for (int k = 0; k < 1024; k++) begin
      expect_wr(k, k);
      strobe(DATAW'(k));
      if (k == 1023) check("frame_done_early", frame_done, 0);
      ticks(3);
    end
    check("f1_frame_done", frame_done, 1);
    check("f1_busy", busy, 0);
    check("f1_overflow", overflow, 0);
    check("f1_pending", exp_q.size(), 0);
    check("f1_writes", n_writes, 1024);

    // Strobe in DONE raises overflow, no write.
    strobe(20'h00066);
    tick();
    check("done_overflow", overflow, 1);
    check("done_we", mem_bus.mem_we, 0);
    check("done_frame_done", frame_done, 1);

    // Memory stall with 5 strobes into a 4-entry FIFO.
    do_start();
    check("st_overflow_clr", overflow, 0);
    check("st_we0", mem_bus.mem_we, 0);
    mem_bus.mem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expect_wr(i - 1, i);
      strobe(DATAW'(i));
      check("stall_we", mem_bus.mem_we, 1);
      check("stall_addr", mem_bus.mem_addr, 0);
      check("stall_wdata", mem_bus.mem_wdata, 1);
      tick();
    end
    check("stall_overflow", overflow, 1);
    mem_bus.mem_ready = 1'b1;
    ticks(6);
    check("stall_pending", exp_q.size(), 0);
    check("stall_overflow_sticky", overflow, 1);

    // Full FIFO with a coincident pop: push accepted.
    do_start();
    check("full_overflow_clr", overflow, 0);
    mem_bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_wr(i, 'h10 + i);
      strobe(DATAW'('h10 + i));
    end
    mem_bus.mem_ready = 1'b1;
    expect_wr(4, 'h14);
    strobe(20'h00014);
    check("full_pop_overflow", overflow, 0);
    ticks(6);
    check("full_pending", exp_q.size(), 0);
    check("full_overflow_after", overflow, 0);

    // Sign bits pass through unchanged.
    expect_wr(5, 'hFFFFF);
    strobe(20'hFFFFF);
    expect_wr(6, 'h80000);
    strobe(20'h80000);
    ticks(3);
    check("neg_pending", exp_q.size(), 0);

    // Reset mid-frame with 3 entries buffered.
    mem_bus.mem_ready = 1'b0;
    strobe(20'h00021);
    strobe(20'h00022);
    strobe(20'h00023);
    check("pre_rst_we", mem_bus.mem_we, 1);
    check("pre_rst_addr", mem_bus.mem_addr, 7);
    check("pre_rst_wdata", mem_bus.mem_wdata, 'h21);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_we", mem_bus.mem_we, 0);
    check("mid_rst_addr", mem_bus.mem_addr, 0);
    check("mid_rst_wdata", mem_bus.mem_wdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overflow", overflow, 0);
    mem_bus.mem_ready = 1'b1;
    ticks(3);
    check("post_rst_we", mem_bus.mem_we, 0);

    // Start mid-frame flushes, clears overflow; coincident strobe is discarded.
    do_start();
    mem_bus.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) strobe(DATAW'('h40 + i));
    check("mid_overflow", overflow, 1);
    check("mid_wdata", mem_bus.mem_wdata, 'h40);
    start     = 1'b1;
    mxpl_done = 1'b1;
    mxpl_data = 20'h00077;
    tick();
    start     = 1'b0;
    mxpl_done = 1'b0;
    check("restart_overflow", overflow, 0);
    check("restart_we", mem_bus.mem_we, 0);
    check("restart_addr", mem_bus.mem_addr, 0);
    check("restart_busy", busy, 1);
    mem_bus.mem_ready = 1'b1;
    expect_wr(0, 'h30);
    strobe(20'h00030);
    tick();
    check("restart_pending", exp_q.size(), 0);

    // Stream the rest of the frame, then one strobe past the frame length.
    for (int k = 1; k <= 1020; k++) begin
      expect_wr(k, k);
      strobe(DATAW'(k));
    end
    tick();
    mem_bus.mem_ready = 1'b0;
    for (int k = 1021; k <= 1023; k++) begin
      expect_wr(k, k);
      strobe(DATAW'(k));
    end
    check("limit_overflow_pre", overflow, 0);
    strobe(20'h00099);
    check("limit_overflow", overflow, 1);
    check("limit_frame_done", frame_done, 0);
    mem_bus.mem_ready = 1'b1;
    ticks(6);
    check("f2_pending", exp_q.size(), 0);
    check("f2_frame_done", frame_done, 1);
    check("f2_busy", busy, 0);
    check("f2_we", mem_bus.mem_we, 0);
    check("stray_writes", n_stray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
